// File: rtl/mc_controller.sv
// mc_controller: multicycle RV32I control FSM (Moore style, one state per
// datapath step). Memory states are guarded by a wait counter that traps
// after MEM_TIMEOUT consecutive not-ready cycles.
// Optional feature: define CTRL_RETIRE_CNT_EN to build the retired-instruction
// counter; without it, retired is tied to zero.
// state_o encoding: IDLE=0 FETCH=1 DECODE=2 EXEC_R=3 EXEC_I=4 MEM_ADDR=5
// MEM_RD=6 MEM_WR=7 WB_ALU=8 WB_MEM=9 BRANCH=10 JAL=11 JALR=12 LUI=13
// AUIPC=14 HALT=15 TRAP=16. Trap causes: 1 memory timeout, 2 ECALL, 3 illegal.
module mc_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int RETIRE_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         ir,
    input  logic                mem_ready,
    input  logic                branch_taken,
    input  logic                resume,
    output logic                mem_req,
    output logic                mem_we,
    output logic                addr_src,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [3:0]          alu_ctrl,
    output logic [1:0]          result_src,
    output logic [1:0]          pc_source,
    output logic                ir_write,
    output logic                pc_write,
    output logic                reg_write,
    output logic                halt,
    output logic                trap,
    output logic [3:0]          trap_cause,
    output logic [4:0]          state_o,
    output logic [RETIRE_W-1:0] retired
);

    typedef enum logic [4:0] {
        S_IDLE     = 5'd0,
        S_FETCH    = 5'd1,
        S_DECODE   = 5'd2,
        S_EXEC_R   = 5'd3,
        S_EXEC_I   = 5'd4,
        S_MEM_ADDR = 5'd5,
        S_MEM_RD   = 5'd6,
        S_MEM_WR   = 5'd7,
        S_WB_ALU   = 5'd8,
        S_WB_MEM   = 5'd9,
        S_BRANCH   = 5'd10,
        S_JAL      = 5'd11,
        S_JALR     = 5'd12,
        S_LUI      = 5'd13,
        S_AUIPC    = 5'd14,
        S_HALT     = 5'd15,
        S_TRAP     = 5'd16
    } state_t;

    localparam logic [7:0] TIMEOUT_M1 = 8'(MEM_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic [3:0] cause_q, cause_d;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       timeout_hit;
    logic       wait_state;
    logic       unused_ir;

    assign opcode      = ir[6:0];
    assign funct3      = ir[14:12];
    assign funct7b5    = ir[30];
    assign unused_ir   = ^{ir[31], ir[29:21], ir[19:15], ir[11:7]};
    assign timeout_hit = (wait_q == TIMEOUT_M1);
    assign wait_state  = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

    // State, wait counter and latched trap cause registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wait_q  <= 8'd0;
            cause_q <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
        end
    end

    // Next-state selection, including opcode decode and memory timeout.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    cause_d = 4'd1;
                end
            end
            S_DECODE: begin
                case (opcode)
                    7'b0110011: state_d = S_EXEC_R;
                    7'b0010011: state_d = S_EXEC_I;
                    7'b0000011: state_d = S_MEM_ADDR;
                    7'b0100011: state_d = S_MEM_ADDR;
                    7'b1100011: state_d = S_BRANCH;
                    7'b1101111: state_d = S_JAL;
                    7'b1100111: state_d = S_JALR;
                    7'b0110111: state_d = S_LUI;
                    7'b0010111: state_d = S_AUIPC;
                    7'b0001111: state_d = S_FETCH;
                    7'b1110011: begin
                        if (ir[20]) begin
                            state_d = S_HALT;
                        end else begin
                            state_d = S_TRAP;
                            cause_d = 4'd2;
                        end
                    end
                    default: begin
                        state_d = S_TRAP;
                        cause_d = 4'd3;
                    end
                endcase
            end
            S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC: state_d = S_WB_ALU;
            S_MEM_ADDR: state_d = ir[5] ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ready) begin
                    state_d = S_WB_MEM;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    cause_d = 4'd1;
                end
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    cause_d = 4'd1;
                end
            end
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL, S_JALR: state_d = S_FETCH;
            S_HALT: if (resume) state_d = S_FETCH;
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

    // Wait counter: runs while a memory state stalls, clears on any state change.
    always_comb begin
        wait_d = 8'd0;
        if (wait_state && !mem_ready && (state_d == state_q)) begin
            wait_d = wait_q + 8'd1;
        end
    end

    // Moore outputs per state; only FETCH and BRANCH look at inputs.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_src   = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_ctrl   = 4'b0000;
        result_src = 2'b00;
        pc_source  = 2'b00;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        halt       = 1'b0;
        trap       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            S_EXEC_R: begin
                alu_src_a = 2'b10;
                alu_ctrl  = {funct7b5, funct3};
            end
            S_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
                alu_ctrl  = {funct7b5 & (funct3 == 3'b101), funct3};
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_req  = 1'b1;
                addr_src = 1'b1;
            end
            S_MEM_WR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_src = 1'b1;
            end
            S_WB_ALU: reg_write = 1'b1;
            S_WB_MEM: begin
                reg_write  = 1'b1;
                result_src = 2'b01;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_ctrl  = 4'b1000;
                pc_write  = branch_taken;
                pc_source = 2'b01;
            end
            S_JAL: begin
                pc_write   = 1'b1;
                pc_source  = 2'b01;
                reg_write  = 1'b1;
                result_src = 2'b10;
            end
            S_JALR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b10;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                result_src = 2'b10;
            end
            S_LUI: alu_src_b = 2'b10;
            S_AUIPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            S_HALT: halt = 1'b1;
            S_TRAP: trap = 1'b1;
            default: ;
        endcase
    end

    assign trap_cause = cause_q;
    assign state_o    = state_q;

`ifdef CTRL_RETIRE_CNT_EN
    logic [RETIRE_W-1:0] retired_q, retired_d;

    // Count one retirement on every return to FETCH from a completing state.
    always_comb begin
        retired_d = retired_q;
        if ((state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_IDLE)) begin
            retired_d = retired_q + RETIRE_W'(1);
        end
    end

    // Retired-instruction counter register, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;
`else
    assign retired = '0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed scenarios plus randomized run of mc_controller,
// checked every cycle against a rule-level behavioural model.
module tb_mc_controller;

    localparam int TIMEOUT = 4;
    localparam int RW      = 8;
`ifdef CTRL_RETIRE_CNT_EN
    localparam bit RET_EN = 1'b1;
`else
    localparam bit RET_EN = 1'b0;
`endif

    typedef enum logic [4:0] {
        S_IDLE = 5'd0, S_FETCH = 5'd1, S_DECODE = 5'd2, S_EXEC_R = 5'd3,
        S_EXEC_I = 5'd4, S_MEM_ADDR = 5'd5, S_MEM_RD = 5'd6, S_MEM_WR = 5'd7,
        S_WB_ALU = 5'd8, S_WB_MEM = 5'd9, S_BRANCH = 5'd10, S_JAL = 5'd11,
        S_JALR = 5'd12, S_LUI = 5'd13, S_AUIPC = 5'd14, S_HALT = 5'd15,
        S_TRAP = 5'd16
    } st_t;

    typedef struct packed {
        logic       mr;
        logic       we;
        logic       as;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] res;
        logic [1:0] pcs;
        logic       irw;
        logic       pcw;
        logic       regw;
        logic       h;
        logic       t;
    } ctl_t;

    localparam logic [31:0] I_ADD    = 32'h002081B3;
    localparam logic [31:0] I_SW     = 32'h0020A423;
    localparam logic [31:0] I_BEQ    = 32'h00208463;
    localparam logic [31:0] I_EBREAK = 32'h00100073;
    localparam logic [31:0] I_ILL    = 32'h0000007F;
    localparam logic [31:0] I_FENCE  = 32'h0000000F;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   ir;
    logic          mem_ready, branch_taken, resume;
    logic          mem_req, mem_we, addr_src;
    logic [1:0]    alu_src_a, alu_src_b;
    logic [3:0]    alu_ctrl;
    logic [1:0]    result_src, pc_source;
    logic          ir_write, pc_write, reg_write, halt, trap;
    logic [3:0]    trap_cause;
    logic [4:0]    state_o;
    logic [RW-1:0] retired;

    int assert_count = 0;
    int fail_count   = 0;

    ctl_t          base [17];
    st_t           m_state;
    int            m_miss;
    logic [3:0]    m_cause;
    logic [RW-1:0] m_ret;
    int            trap_streak;

    mc_controller #(.MEM_TIMEOUT(TIMEOUT), .RETIRE_W(RW)) dut (
        .clk(clk), .rst(rst), .ir(ir), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .resume(resume),
        .mem_req(mem_req), .mem_we(mem_we), .addr_src(addr_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .result_src(result_src), .pc_source(pc_source),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .halt(halt), .trap(trap), .trap_cause(trap_cause),
        .state_o(state_o), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        assert_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] expRet(input int n);
        return RET_EN ? 64'(n % (1 << RW)) : 64'd0;
    endfunction

    function automatic ctl_t mk(input logic mr, we, as, input logic [1:0] a, b, res, pcs,
                                input logic irw, pcw, regw, h, t);
        return '{mr, we, as, a, b, res, pcs, irw, pcw, regw, h, t};
    endfunction

    // Where DECODE sends an instruction and with what trap cause.
    task automatic decodeTarget(input logic [31:0] i, output st_t n, output logic [3:0] c);
        c = 4'd0;
        case (i[6:0])
            7'b0110011: n = S_EXEC_R;
            7'b0010011: n = S_EXEC_I;
            7'b0000011, 7'b0100011: n = S_MEM_ADDR;
            7'b1100011: n = S_BRANCH;
            7'b1101111: n = S_JAL;
            7'b1100111: n = S_JALR;
            7'b0110111: n = S_LUI;
            7'b0010111: n = S_AUIPC;
            7'b0001111: n = S_FETCH;
            7'b1110011: begin n = i[20] ? S_HALT : S_TRAP; c = i[20] ? 4'd0 : 4'd2; end
            default: begin n = S_TRAP; c = 4'd3; end
        endcase
    endtask

    // Expected output vector for the model state and the present inputs.
    function automatic logic [28:0] modelOutputs(input st_t s, input logic [31:0] i,
                                                 input logic rdy, tk, input logic [3:0] cause);
        ctl_t c;
        logic [3:0] alu;
        c = base[s];
        if (s == S_FETCH && rdy) begin c.irw = 1'b1; c.pcw = 1'b1; end
        if (s == S_BRANCH) c.pcw = tk;
        alu = 4'd0;
        if (s == S_EXEC_R) alu = {i[30], i[14:12]};
        if (s == S_EXEC_I) alu = {i[30] & (i[14:12] == 3'b101), i[14:12]};
        if (s == S_BRANCH) alu = 4'b1000;
        return {c.mr, c.we, c.as, c.a, c.b, alu, c.res, c.pcs, c.irw, c.pcw, c.regw,
                c.h, c.t, (s == S_TRAP) ? cause : 4'd0, 5'(s)};
    endfunction

    // Per-state constant control table taken straight from the state descriptions.
    initial begin
        for (int k = 0; k < 17; k++) base[k] = '0;
        base[S_FETCH]    = mk(1, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        base[S_DECODE]   = mk(0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        base[S_EXEC_R]   = mk(0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        base[S_EXEC_I]   = mk(0, 0, 0, 2'b10, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        base[S_MEM_ADDR] = mk(0, 0, 0, 2'b10, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        base[S_MEM_RD]   = mk(1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        base[S_MEM_WR]   = mk(1, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        base[S_WB_ALU]   = mk(0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 0);
        base[S_WB_MEM]   = mk(0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 0, 0, 1, 0, 0);
        base[S_BRANCH]   = mk(0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b01, 0, 0, 0, 0, 0);
        base[S_JAL]      = mk(0, 0, 0, 2'b00, 2'b00, 2'b10, 2'b01, 0, 1, 1, 0, 0);
        base[S_JALR]     = mk(0, 0, 0, 2'b10, 2'b10, 2'b10, 2'b00, 0, 1, 1, 0, 0);
        base[S_LUI]      = mk(0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        base[S_AUIPC]    = mk(0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        base[S_HALT]     = mk(0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0);
        base[S_TRAP]     = mk(0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1);
    end

    // Compare process: check DUT against the model every cycle, then step the model.
    initial begin
        logic [28:0] exp_v, act_v;
        st_t         nxt;
        logic [3:0]  ncause;
        bit          is_wait;
        m_state = S_IDLE; m_miss = 0; m_cause = 4'd0; m_ret = '0; trap_streak = 0;
        forever begin
            @(negedge clk);
            act_v = {mem_req, mem_we, addr_src, alu_src_a, alu_src_b, alu_ctrl, result_src,
                     pc_source, ir_write, pc_write, reg_write, halt, trap, trap_cause, state_o};
            if (rst) begin
                m_state = S_IDLE; m_miss = 0; m_cause = 4'd0; m_ret = '0;
                checkOutput("model_outputs_rst", 64'(act_v), 64'd0);
                checkOutput("model_retired_rst", 64'(retired), 64'd0);
            end else begin
                exp_v = modelOutputs(m_state, ir, mem_ready, branch_taken, m_cause);
                checkOutput("model_outputs", 64'(act_v), 64'(exp_v));
                checkOutput("model_retired", 64'(retired), RET_EN ? 64'(m_ret) : 64'd0);
                ncause  = 4'd0;
                is_wait = (m_state == S_FETCH) || (m_state == S_MEM_RD) || (m_state == S_MEM_WR);
                case (m_state)
                    S_IDLE:   nxt = S_FETCH;
                    S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
                    S_MEM_RD: nxt = mem_ready ? S_WB_MEM : S_MEM_RD;
                    S_MEM_WR: nxt = mem_ready ? S_FETCH  : S_MEM_WR;
                    S_DECODE: decodeTarget(ir, nxt, ncause);
                    S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC: nxt = S_WB_ALU;
                    S_MEM_ADDR: nxt = ir[5] ? S_MEM_WR : S_MEM_RD;
                    S_HALT:   nxt = resume ? S_FETCH : S_HALT;
                    S_TRAP:   nxt = S_TRAP;
                    default:  nxt = S_FETCH;
                endcase
                if (is_wait && !mem_ready && (m_miss + 1 >= TIMEOUT)) begin
                    nxt = S_TRAP; ncause = 4'd1;
                end
                if (nxt == S_FETCH && m_state != S_FETCH && m_state != S_IDLE) m_ret = m_ret + 1'b1;
                if (nxt == S_TRAP && m_state != S_TRAP) m_cause = ncause;
                m_miss = (is_wait && !mem_ready && nxt == m_state) ? m_miss + 1 : 0;
                trap_streak = (nxt == S_TRAP) ? trap_streak + 1 : 0;
                m_state = nxt;
            end
        end
    end

    // One cycle of stimulus: drive just after the rising edge, settle to the falling edge.
    task automatic applyStimulus(input logic [31:0] i, input logic rdy, tk, res);
        @(posedge clk);
        #1;
        rst = 1'b0; ir = i; mem_ready = rdy; branch_taken = tk; resume = res;
        @(negedge clk);
    endtask

    task automatic resetDut();
        @(posedge clk);
        #1;
        rst = 1'b1; mem_ready = 1'b0; resume = 1'b0; branch_taken = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [6:0]  ops [11];
        logic [31:0] r;
        logic [6:0]  op;
        int          pick;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F, 7'h73};

        rst = 1'b1; ir = '0; mem_ready = 1'b0; branch_taken = 1'b0; resume = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_state", 64'(state_o), 64'(S_IDLE));
        checkOutput("reset_mem_req", 64'(mem_req), 64'd0);
        checkOutput("reset_retired", 64'(retired), 64'd0);

        // ADD x3,x1,x2 through the R-type path.
        applyStimulus(I_ADD, 0, 0, 0);
        checkOutput("add_idle", 64'(state_o), 64'(S_IDLE));
        applyStimulus(I_ADD, 1, 0, 0);
        checkOutput("add_fetch_irw", 64'({ir_write, pc_write, mem_req, pc_source}), 64'b11100);
        applyStimulus(I_ADD, 0, 0, 0);
        checkOutput("add_decode", 64'(state_o), 64'(S_DECODE));
        applyStimulus(I_ADD, 0, 0, 0);
        checkOutput("add_exec_r", 64'({state_o, alu_ctrl}), 64'({S_EXEC_R, 4'b0000}));
        applyStimulus(I_ADD, 0, 0, 0);
        checkOutput("add_wb_alu", 64'({state_o, reg_write}), 64'({S_WB_ALU, 1'b1}));
        applyStimulus(I_SW, 0, 0, 0);
        checkOutput("add_back_fetch", 64'(state_o), 64'(S_FETCH));
        checkOutput("add_retired", 64'(retired), expRet(1));

        // SW with three stalled write cycles.
        applyStimulus(I_SW, 1, 0, 0);
        applyStimulus(I_SW, 0, 0, 0);
        applyStimulus(I_SW, 0, 0, 0);
        checkOutput("sw_mem_addr", 64'(state_o), 64'(S_MEM_ADDR));
        for (int k = 0; k < 4; k++) begin
            applyStimulus(I_SW, (k == 3), 0, 0);
            checkOutput("sw_mem_wr", 64'({state_o, mem_req, mem_we}), 64'({S_MEM_WR, 2'b11}));
        end

        // Timeout in FETCH: four stalled cycles then TRAP with cause 1.
        for (int k = 0; k < TIMEOUT; k++) begin
            applyStimulus(I_ADD, 0, 0, 0);
            checkOutput("timeout_fetch", 64'(state_o), 64'(S_FETCH));
        end
        checkOutput("sw_retired", 64'(retired), expRet(2));
        applyStimulus(I_ADD, 0, 0, 0);
        checkOutput("timeout_trap", 64'({state_o, trap, trap_cause}), 64'({S_TRAP, 1'b1, 4'd1}));
        applyStimulus(I_ADD, 1, 0, 1);
        checkOutput("trap_holds", 64'({state_o, trap, trap_cause}), 64'({S_TRAP, 1'b1, 4'd1}));
        resetDut();
        checkOutput("trap_reset", 64'({trap, trap_cause, retired}), 64'd0);

        // BEQ not taken, then taken.
        applyStimulus(I_BEQ, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(I_BEQ, 1, 0, 0);
            applyStimulus(I_BEQ, 0, 0, 0);
            applyStimulus(I_BEQ, 0, logic'(k), 0);
            checkOutput("beq_branch", 64'({state_o, alu_ctrl, pc_write, pc_source}),
                        64'({S_BRANCH, 4'b1000, logic'(k), 2'b01}));
        end

        // EBREAK with resume ignored outside HALT, then five HALT cycles.
        applyStimulus(I_EBREAK, 1, 0, 1);
        applyStimulus(I_EBREAK, 0, 0, 1);
        checkOutput("ebreak_decode", 64'(state_o), 64'(S_DECODE));
        for (int k = 0; k < 5; k++) begin
            applyStimulus(I_EBREAK, 0, 0, (k == 4));
            checkOutput("halt_flag", 64'({state_o, halt}), 64'({S_HALT, 1'b1}));
        end
        applyStimulus(I_ILL, 1, 0, 0);
        checkOutput("halt_exit", 64'(state_o), 64'(S_FETCH));
        checkOutput("halt_retired", 64'(retired), expRet(3));

        // Illegal opcode, then asynchronous reset while trapped.
        applyStimulus(I_ILL, 0, 0, 0);
        applyStimulus(I_ILL, 0, 0, 0);
        checkOutput("illegal_trap", 64'({state_o, trap, trap_cause}), 64'({S_TRAP, 1'b1, 4'd3}));
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_trap", 64'({state_o, trap, retired}), 64'd0);
        @(negedge clk);

        // Asynchronous reset in the middle of a fetch drops the request at once.
        applyStimulus(I_ADD, 0, 0, 0);
        applyStimulus(I_ADD, 0, 0, 0);
        checkOutput("fetch_req", 64'(mem_req), 64'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_mem_req", 64'({mem_req, state_o}), 64'd0);
        @(negedge clk);

        // Retired counter wrap: 258 fences into an 8-bit counter leave 2.
        applyStimulus(I_FENCE, 0, 0, 0);
        for (int k = 0; k < 258; k++) begin
            applyStimulus(I_FENCE, 1, 0, 0);
            applyStimulus(I_FENCE, 0, 0, 0);
        end
        applyStimulus(I_FENCE, 0, 0, 0);
        checkOutput("retired_wrap", 64'(retired), expRet(258));

        // Randomized run; reset whenever the controller has sat in TRAP for a while.
        resetDut();
        for (int n = 0; n < 4000; n++) begin
            if (trap_streak > 2 || $urandom_range(0, 299) == 0) begin
                resetDut();
            end else begin
                r    = $urandom;
                pick = $urandom_range(0, 11);
                op   = (pick < 11) ? ops[pick] : 7'($urandom_range(0, 127));
                applyStimulus({r[31:7], op}, ($urandom_range(0, 99) < 65),
                              1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 30));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
